// File: rtl/irq_ack_ctrl_mc.sv
// Multi-channel interrupt-acknowledge controller: round-robin channel select, 8-state FSM, timeout watchdog.
// Optional build macro CH_MASK_EN adds a ch_mask input that restricts which channels the round-robin visits.
module irq_ack_ctrl_mc #(
  parameter  int NUM_CH  = 4,
  parameter  int TMO_W   = 4,
  parameter  int TMO_CYC = 10,
  localparam int SEL_W   = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] eql,
`ifdef CH_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  input  logic              cont_eql,
  output logic [SEL_W-1:0]  sel,
  output logic [1:0]        cc_mux,
  output logic [1:0]        uscite,
  output logic              enable_count,
  output logic              ackout,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'b000,
    ST_WAIT  = 3'b001,
    ST_MATCH = 3'b010,
    ST_ACK   = 3'b011,
    ST_HOLD  = 3'b100,
    ST_ALT   = 3'b101,
    ST_RECOV = 3'b110,
    ST_ERR   = 3'b111
  } state_t;

  state_t            state_r;
  logic [SEL_W-1:0]  sel_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [1:0]        cc_mux_r;
  logic [1:0]        uscite_r;
  logic              enable_count_r;
  logic              ackout_r;
  logic              timeout_err_r;

  logic              ch_eql_s;
  logic [SEL_W-1:0]  adv_sel_s;
  logic [TMO_W-1:0]  tmo_inc_s;
  logic              tmo_limit_s;

`ifdef CH_MASK_EN
  // First enabled channel strictly after cur, wrapping; cur itself if it is the only one; hold if none.
  function automatic logic [SEL_W-1:0] next_enabled_f(input logic [SEL_W-1:0] cur,
                                                      input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] res_v;
    logic [SEL_W-1:0] idx_v;
    logic             found_v;
    res_v   = cur;
    found_v = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_v = SEL_W'((int'(cur) + k) % NUM_CH);
      if (!found_v && mask[idx_v]) begin
        res_v   = idx_v;
        found_v = 1'b1;
      end else begin
        res_v   = res_v;
      end
    end
    return res_v;
  endfunction
`endif

  // Request line of the served channel, optionally gated by the mask while waiting.
  always_comb begin
    ch_eql_s = eql[sel_r];
`ifdef CH_MASK_EN
    if ((state_r == ST_WAIT) && !ch_mask[sel_r]) begin
      ch_eql_s = 1'b0;
    end else begin
      ch_eql_s = eql[sel_r];
    end
`endif
  end

  // Channel that the next +adv arc will load into sel.
  always_comb begin
    adv_sel_s = sel_r;
`ifdef CH_MASK_EN
    adv_sel_s = next_enabled_f(sel_r, ch_mask);
`else
    if (sel_r == SEL_W'(NUM_CH - 1)) begin
      adv_sel_s = {SEL_W{1'b0}};
    end else begin
      adv_sel_s = sel_r + SEL_W'(1);
    end
`endif
  end

  // Watchdog helpers: saturating increment and the stay that would reach the limit.
  always_comb begin
    if (tmo_cnt_r == {TMO_W{1'b1}}) begin
      tmo_inc_s = tmo_cnt_r;
    end else begin
      tmo_inc_s = tmo_cnt_r + TMO_W'(1);
    end
    tmo_limit_s = (tmo_cnt_r >= TMO_W'(TMO_CYC - 1));
  end

  // Controller FSM with registered outputs; arcs into WAIT marked adv also step sel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_INIT;
      sel_r          <= {SEL_W{1'b0}};
      tmo_cnt_r      <= {TMO_W{1'b0}};
      cc_mux_r       <= 2'b00;
      uscite_r       <= 2'b00;
      enable_count_r <= 1'b0;
      ackout_r       <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      ackout_r       <= ~cont_eql;
      enable_count_r <= ~cont_eql;
      timeout_err_r  <= 1'b0;
      case (state_r)
        ST_INIT: begin
          state_r  <= ST_WAIT;
          uscite_r <= 2'b01;
          cc_mux_r <= 2'b01;
        end
        ST_WAIT: begin
          if (ch_eql_s) begin
            state_r   <= ST_MATCH;
            uscite_r  <= 2'b00;
            cc_mux_r  <= 2'b11;
            tmo_cnt_r <= {TMO_W{1'b0}};
          end else begin
            state_r  <= ST_ALT;
            uscite_r <= 2'b01;
            cc_mux_r <= 2'b10;
          end
        end
        ST_ALT: begin
          if (ch_eql_s) begin
            state_r   <= ST_HOLD;
            uscite_r  <= 2'b00;
            cc_mux_r  <= 2'b11;
            tmo_cnt_r <= {TMO_W{1'b0}};
          end else begin
            state_r  <= ST_WAIT;
            uscite_r <= 2'b01;
            cc_mux_r <= 2'b01;
            sel_r    <= adv_sel_s;
          end
        end
        ST_MATCH: begin
          if (ch_eql_s) begin
            if (tmo_limit_s) begin
              state_r       <= ST_ERR;
              uscite_r      <= 2'b10;
              cc_mux_r      <= 2'b00;
              timeout_err_r <= 1'b1;
            end else begin
              state_r   <= ST_MATCH;
              uscite_r  <= 2'b00;
              cc_mux_r  <= 2'b11;
              tmo_cnt_r <= tmo_inc_s;
            end
          end else begin
            // Acknowledge entry wins over the counter-equal drop.
            state_r        <= ST_ACK;
            uscite_r       <= 2'b01;
            cc_mux_r       <= 2'b01;
            ackout_r       <= 1'b1;
            enable_count_r <= 1'b1;
          end
        end
        ST_ACK: begin
          if (ch_eql_s) begin
            state_r  <= ST_ACK;
            uscite_r <= 2'b01;
            cc_mux_r <= 2'b01;
          end else begin
            state_r  <= ST_WAIT;
            uscite_r <= 2'b01;
            cc_mux_r <= 2'b01;
            sel_r    <= adv_sel_s;
          end
        end
        ST_HOLD: begin
          if (ch_eql_s) begin
            if (tmo_limit_s) begin
              state_r       <= ST_ERR;
              uscite_r      <= 2'b10;
              cc_mux_r      <= 2'b00;
              timeout_err_r <= 1'b1;
            end else begin
              state_r   <= ST_HOLD;
              uscite_r  <= 2'b00;
              cc_mux_r  <= 2'b11;
              tmo_cnt_r <= tmo_inc_s;
            end
          end else begin
            state_r  <= ST_RECOV;
            uscite_r <= 2'b11;
            cc_mux_r <= 2'b10;
          end
        end
        ST_RECOV: begin
          if (ch_eql_s) begin
            state_r  <= ST_RECOV;
            uscite_r <= 2'b11;
            cc_mux_r <= 2'b10;
          end else begin
            state_r  <= ST_WAIT;
            uscite_r <= 2'b01;
            cc_mux_r <= 2'b01;
            sel_r    <= adv_sel_s;
          end
        end
        ST_ERR: begin
          if (ch_eql_s) begin
            state_r       <= ST_ERR;
            uscite_r      <= 2'b10;
            cc_mux_r      <= 2'b00;
            timeout_err_r <= 1'b1;
          end else begin
            state_r  <= ST_WAIT;
            uscite_r <= 2'b01;
            cc_mux_r <= 2'b01;
            sel_r    <= adv_sel_s;
          end
        end
        default: begin
          state_r  <= ST_INIT;
          uscite_r <= 2'b00;
          cc_mux_r <= 2'b00;
        end
      endcase
    end
  end

  assign sel          = sel_r;
  assign cc_mux       = cc_mux_r;
  assign uscite       = uscite_r;
  assign enable_count = enable_count_r;
  assign ackout       = ackout_r;
  assign timeout_err  = timeout_err_r;

endmodule
